// File: rtl/uart_fifo.sv
// uart_fifo: Wishbone UART with TX/RX FIFOs,
// 16x oversampled majority-vote RX, parity, 1/2 stop.
module uart_fifo_buf #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic [$clog2(DEPTH):0]  cnt,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = cnt == FULL_CNT;
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    // storage array, written on accepted pushes
    always_ff @(posedge clk)
        if (do_push && !clr)
            mem[wp] <= din;

    // wrap-around pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module uart_fifo #(
    parameter int ADDR_WIDTH   = 8,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_we,
    input  logic [3:0]            wb_sel,
    input  logic                  wb_stb,
    output logic                  wb_ack,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    output logic                  irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_RST =
        16'(CLK_FREQ / (16 * DEFAULT_BAUD));

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } st_t;

    logic          acc, wr, rd;
    logic [5:0]    idx;
    logic          wr_data, wr_stat, wr_ctrl, wr_baud, rd_data;
    logic [6:0]    ctrl;
    logic [15:0]   baud_div, bcnt, div_m1;
    logic          tick;
    logic          rx_ovr, frm_err, par_err, tx_ovf;
    logic [31:0]   rdata;
    logic          unused_ok;

    assign acc     = wb_stb && !wb_ack;
    assign wr      = acc && wb_we;
    assign rd      = acc && !wb_we;
    assign idx     = wb_addr[7:2];
    assign wr_data = wr && idx == 6'h0;
    assign wr_stat = wr && idx == 6'h1;
    assign wr_ctrl = wr && idx == 6'h2;
    assign wr_baud = wr && idx == 6'h3;
    assign rd_data = rd && idx == 6'h0;
    assign unused_ok = ^{wb_sel, wb_dat_i[31:16], wb_addr[1:0]};

    // FIFOs
    logic [7:0]    tx_dout, rx_dout;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_pop, rx_push;
    logic [7:0]    rx_sh;

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_txf (
        .clk(clk), .rst_n(rst_n),
        .clr(wr_ctrl && wb_dat_i[7]),
        .push(wr_data), .pop(tx_pop),
        .din(wb_dat_i[7:0]), .dout(tx_dout),
        .cnt(tx_cnt), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rxf (
        .clk(clk), .rst_n(rst_n),
        .clr(wr_ctrl && wb_dat_i[8]),
        .push(rx_push), .pop(rd_data),
        .din(rx_sh), .dout(rx_dout),
        .cnt(rx_cnt), .full(rx_full), .empty(rx_empty)
    );

    // oversample tick generator, restarted on divider writes
    assign div_m1 = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    assign tick   = bcnt == div_m1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               bcnt <= '0;
        else if (wr_baud || tick) bcnt <= '0;
        else                      bcnt <= bcnt + 16'd1;
    end

    // TX
    st_t        tx_st, tx_nx;
    logic [4:0] tx_tk;
    logic [2:0] tx_bit;
    logic [7:0] tx_sh;
    logic       tx_par, tx_go, tx_bend, tx_send, tx_o, tx_idle;

    assign tx_go   = ctrl[1] && !tx_empty;
    assign tx_bend = tick && tx_tk == 5'd15;
    assign tx_send = tick && tx_tk == (ctrl[6] ? 5'd31 : 5'd15);
    assign tx_idle = tx_empty && tx_st == S_IDLE;

    // TX next-state and FIFO pop decision
    always_comb begin
        tx_nx  = tx_st;
        tx_pop = 1'b0;
        unique case (tx_st)
            S_IDLE: if (tx_go) begin
                tx_pop = 1'b1;
                tx_nx  = S_START;
            end
            S_START: if (tx_bend) tx_nx = S_DATA;
            S_DATA: if (tx_bend && tx_bit == 3'd7)
                tx_nx = ctrl[4] ? S_PAR : S_STOP;
            S_PAR: if (tx_bend) tx_nx = S_STOP;
            S_STOP: if (tx_send) begin
                if (tx_go) begin
                    tx_pop = 1'b1;
                    tx_nx  = S_START;
                end else begin
                    tx_nx = S_IDLE;
                end
            end
            default: tx_nx = S_IDLE;
        endcase
    end

    // TX state, tick counter and shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st  <= S_IDLE;
            tx_tk  <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx_par <= 1'b0;
        end else begin
            tx_st <= tx_nx;
            if (tx_pop || tx_st == S_IDLE)
                tx_tk <= '0;
            else if (tick)
                tx_tk <= (tx_st != S_STOP && tx_tk == 5'd15) ?
                         5'd0 : tx_tk + 5'd1;
            if (tx_pop) begin
                tx_sh  <= tx_dout;
                tx_par <= ^tx_dout ^ ctrl[5];
                tx_bit <= '0;
            end else if (tx_st == S_DATA && tx_bend) begin
                tx_sh  <= tx_sh >> 1;
                tx_bit <= tx_bit + 3'd1;
            end
        end
    end

    // TX line level decoded from state
    always_comb begin
        tx_o = 1'b1;
        unique case (tx_st)
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = tx_sh[0];
            S_PAR:   tx_o = tx_par;
            default: tx_o = 1'b1;
        endcase
    end
    assign uart_tx = tx_o;

    // RX
    logic       rx_s1, rx_s2, rx_d;
    st_t        rx_st, rx_nx;
    logic [3:0] rx_tk;
    logic [2:0] rx_bit;
    logic [1:0] rx_smp;
    logic       rx_mid, rx_end, rx_maj, rx_pbit;
    logic       set_ovr, set_frm, set_par;

    // two-flop synchroniser plus one stage of edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_mid  = tick && rx_tk == 4'd9;
    assign rx_end  = tick && rx_tk == 4'd15;
    assign rx_maj  = (rx_smp[0] & rx_smp[1]) |
                     (rx_smp[0] & rx_s2) |
                     (rx_smp[1] & rx_s2);
    assign rx_pbit = ^rx_sh ^ ctrl[5];

    // RX next-state, push and error decisions
    always_comb begin
        rx_nx   = rx_st;
        rx_push = 1'b0;
        set_ovr = 1'b0;
        set_frm = 1'b0;
        set_par = 1'b0;
        if (!ctrl[0]) begin
            rx_nx = S_IDLE;
        end else begin
            unique case (rx_st)
                S_IDLE: if (rx_d && !rx_s2) rx_nx = S_START;
                S_START:
                    if (rx_mid && rx_maj) rx_nx = S_IDLE;
                    else if (rx_end)      rx_nx = S_DATA;
                S_DATA: if (rx_end && rx_bit == 3'd7)
                    rx_nx = ctrl[4] ? S_PAR : S_STOP;
                S_PAR: begin
                    if (rx_mid && rx_maj != rx_pbit) set_par = 1'b1;
                    if (rx_end) rx_nx = S_STOP;
                end
                S_STOP: if (rx_mid) begin
                    rx_nx = S_IDLE;
                    if (!rx_maj)      set_frm = 1'b1;
                    else if (rx_full) set_ovr = 1'b1;
                    else              rx_push = 1'b1;
                end
                default: rx_nx = S_IDLE;
            endcase
        end
    end

    // RX state, tick counter, vote samples and shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st  <= S_IDLE;
            rx_tk  <= '0;
            rx_bit <= '0;
            rx_smp <= '0;
            rx_sh  <= '0;
        end else begin
            rx_st <= rx_nx;
            if (rx_st == S_IDLE) rx_tk <= '0;
            else if (tick)       rx_tk <= rx_tk + 4'd1;
            if (tick && rx_tk == 4'd7) rx_smp[0] <= rx_s2;
            if (tick && rx_tk == 4'd8) rx_smp[1] <= rx_s2;
            if (rx_st == S_DATA && rx_mid)
                rx_sh <= {rx_maj, rx_sh[7:1]};
            if (rx_st == S_IDLE)
                rx_bit <= '0;
            else if (rx_st == S_DATA && rx_end)
                rx_bit <= rx_bit + 3'd1;
        end
    end

    // control, divider and sticky W1C flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= 7'h03;
            baud_div <= DIV_RST;
            rx_ovr   <= 1'b0;
            frm_err  <= 1'b0;
            par_err  <= 1'b0;
            tx_ovf   <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= wb_dat_i[6:0];
            if (wr_baud) baud_div <= wb_dat_i[15:0];
            rx_ovr  <= set_ovr |
                       (rx_ovr & ~(wr_stat & wb_dat_i[2]));
            frm_err <= set_frm |
                       (frm_err & ~(wr_stat & wb_dat_i[3]));
            par_err <= set_par |
                       (par_err & ~(wr_stat & wb_dat_i[4]));
            tx_ovf  <= (wr_data & tx_full) |
                       (tx_ovf & ~(wr_stat & wb_dat_i[7]));
        end
    end

    // register read mux
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            idx == 6'h0: rdata = rx_empty ? 32'd0 : {24'd0, rx_dout};
            idx == 6'h1: rdata = {24'd0, tx_ovf, rx_full, tx_full,
                                  par_err, frm_err, rx_ovr,
                                  tx_idle, !rx_empty};
            idx == 6'h2: rdata = {25'd0, ctrl};
            idx == 6'h3: rdata = {16'd0, baud_div};
            idx == 6'h4: rdata = {16'd0, 8'(rx_cnt), 8'(tx_cnt)};
            default:     rdata = '0;
        endcase
    end

    // bus handshake, read data and interrupt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_dat_o <= '0;
            irq      <= 1'b0;
        end else begin
            wb_ack <= wb_stb && !wb_ack;
            if (rd) wb_dat_o <= rdata;
            irq <= (ctrl[2] & !rx_empty) | (ctrl[3] & tx_idle);
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo,
// hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  wb_addr = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'hf;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        rx_line;
    logic        uart_tx;
    logic        irq;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    assign rx_line = loop ? uart_tx : rx_drv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_fifo dut (
        .clk(clk), .rst_n(rst_n),
        .wb_addr(wb_addr), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_stb(wb_stb),
        .wb_ack(wb_ack), .uart_rx(rx_line),
        .uart_tx(uart_tx), .irq(irq)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic [7:0] a,
                           input logic we,
                           input logic [31:0] d,
                           output logic [31:0] q);
        int k;
        @(posedge clk); #1;
        wb_addr = a; wb_dat_i = d; wb_we = we; wb_stb = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!wb_ack && k < 8);
        check("wb_ack", {31'd0, wb_ack}, 32'd1);
        q = wb_dat_o;
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(a, 1'b1, d, q);
    endtask

    task automatic rd_chk(input string tag,
                          input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(a, 1'b0, 32'd0, q);
        check(tag, q, exp);
    endtask

    // capture one TX frame; returns byte, parity, stop, start cycle
    task automatic cap_frame(input bit par,
                             output logic [7:0] b,
                             output logic pb,
                             output logic stp,
                             output int t0);
        int k;
        k = 0;
        pb = 1'b0;
        while (uart_tx && k < 3000) begin
            step(1);
            k++;
        end
        check("tx_start_seen", {31'd0, uart_tx}, 32'd0);
        t0 = cyc;
        step(8);
        check("tx_start_mid", {31'd0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(16);
            b[i] = uart_tx;
        end
        if (par) begin
            step(16);
            pb = uart_tx;
        end
        step(16);
        stp = uart_tx;
    endtask

    task automatic drive_frame(input logic [7:0] b,
                               input logic stopv);
        rx_drv = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            step(16);
        end
        rx_drv = stopv;
        step(16);
        rx_drv = 1'b1;
        step(16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] q;
        logic        pb, stp, hit;
        int          t0, tp, len;

        step(3);
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        rst_n = 1'b1;
        step(2);
        rd_chk("rst_status", 8'h04, 32'h002);
        rd_chk("rst_ctrl", 8'h08, 32'h003);
        rd_chk("rst_baud", 8'h0C, 32'd27);
        rd_chk("rst_level", 8'h10, 32'h0);
        rd_chk("rst_rxempty", 8'h00, 32'h0);
        rd_chk("unmapped", 8'h14, 32'h0);

        // single frame 0xA5 at one tick per clock
        wb_wr(8'h0C, 32'd1);
        wb_wr(8'h00, 32'hA5);
        len = 0;
        while (uart_tx && len < 100) begin
            step(1);
            len++;
        end
        len = 0;
        while (!uart_tx && len < 100) begin
            step(1);
            len++;
        end
        check("a5_start_len", len, 32'd16);
        step(8);
        for (int i = 0; i < 8; i++) begin
            b[i] = uart_tx;
            if (i < 7) step(16);
        end
        check("a5_byte", {24'd0, b}, 32'hA5);
        step(16);
        check("a5_stop", {31'd0, uart_tx}, 32'd1);
        step(16);
        rd_chk("a5_idle", 8'h04, 32'h002);

        // overflow with TX disabled, then 16 back-to-back
        wb_wr(8'h08, 32'h001);
        for (int i = 0; i < 17; i++)
            wb_wr(8'h00, 32'h10 + i);
        rd_chk("ovf_level", 8'h10, 32'h0010);
        rd_chk("ovf_status", 8'h04, 32'h0A0);
        wb_wr(8'h04, 32'h80);
        rd_chk("ovf_w1c", 8'h04, 32'h020);
        wb_wr(8'h08, 32'h003);
        tp = 0;
        for (int i = 0; i < 16; i++) begin
            cap_frame(1'b0, b, pb, stp, t0);
            check($sformatf("b2b_byte%0d", i), {24'd0, b}, 32'h10 + i);
            check($sformatf("b2b_stop%0d", i), {31'd0, stp}, 32'd1);
            if (i > 0)
                check($sformatf("b2b_gap%0d", i), t0 - tp, 32'd160);
            tp = t0;
        end
        step(20);
        rd_chk("b2b_idle", 8'h04, 32'h002);
        rd_chk("b2b_level", 8'h10, 32'h0);

        // loopback, odd parity, two stop bits
        loop = 1'b1;
        wb_wr(8'h08, 32'h073);
        wb_wr(8'h00, 32'h3C);
        step(260);
        rd_chk("lb_status", 8'h04, 32'h003);
        rd_chk("lb_data", 8'h00, 32'h3C);
        rd_chk("lb_level", 8'h10, 32'h0);
        rd_chk("lb_status2", 8'h04, 32'h002);
        wb_wr(8'h08, 32'h003);
        step(4);
        loop = 1'b0;

        // parity bit on the line: 0x3C even weight, odd -> 1
        wb_wr(8'h08, 32'h032);
        wb_wr(8'h00, 32'h3C);
        cap_frame(1'b1, b, pb, stp, t0);
        check("par_byte", {24'd0, b}, 32'h3C);
        check("par_bit", {31'd0, pb}, 32'd1);
        step(40);
        wb_wr(8'h08, 32'h003);

        // framing error
        drive_frame(8'h5A, 1'b0);
        rd_chk("frm_status", 8'h04, 32'h00A);
        wb_wr(8'h04, 32'h08);
        rd_chk("frm_w1c", 8'h04, 32'h002);

        // overrun after 17 frames
        for (int i = 0; i < 17; i++)
            drive_frame(8'h30 + 8'(i), 1'b1);
        rd_chk("ovr_status", 8'h04, 32'h047);
        rd_chk("ovr_level", 8'h10, 32'h1000);
        rd_chk("ovr_first", 8'h00, 32'h30);
        rd_chk("ovr_level2", 8'h10, 32'h0F00);
        wb_wr(8'h08, 32'h103);
        rd_chk("rxclr_ctrl", 8'h08, 32'h003);
        rd_chk("rxclr_level", 8'h10, 32'h0);
        wb_wr(8'h04, 32'h04);
        rd_chk("ovr_w1c", 8'h04, 32'h002);

        // RX interrupt
        wb_wr(8'h08, 32'h007);
        step(2);
        check("irq_quiet", {31'd0, irq}, 32'd0);
        rx_drv = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[0] ^ b[0] ^ ((8'h55 >> i) & 8'h01) != 0;
            step(16);
        end
        check("irq_pre_stop", {31'd0, irq}, 32'd0);
        rx_drv = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(1);
            if (irq) hit = 1'b1;
        end
        check("irq_rise", {31'd0, hit}, 32'd1);
        step(8);
        wb_xfer(8'h00, 1'b0, 32'd0, q);
        check("irq_data", q, 32'h55);
        check("irq_hold", {31'd0, irq}, 32'd1);
        step(1);
        check("irq_fall", {31'd0, irq}, 32'd0);

        // one-clock glitch is a false start
        rx_drv = 1'b0;
        step(1);
        rx_drv = 1'b1;
        step(200);
        rd_chk("glitch_status", 8'h04, 32'h002);
        rd_chk("glitch_level", 8'h10, 32'h0);
        check("glitch_irq", {31'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Next-generation debug/communication UART on the SoC Wishbone peripheral bus. It adds parametrised TX/RX FIFOs, 16x oversampled RX with majority voting, and optional parity (even/odd). It also supports 1 or 2 stop bits, sticky error flags with write-1-to-clear, and TX/RX interrupt sources. Frames carry 8 data bits, LSB first.

Parameters:
ADDR_WIDTH, 8, Wishbone address width; the register index is wb_addr[7:2].
CLK_FREQ, 50_000_000, system clock frequency in Hz.
DEFAULT_BAUD, 115200, baud rate after reset.
FIFO_DEPTH, 16, entries per FIFO; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous, active-low.
wb_addr  in  ADDR_WIDTH  register byte address.
wb_dat_i  in  32  write data.
wb_dat_o  out  32  read data; registered.
wb_we  in  1  write enable.
wb_sel  in  4  byte selects; ignored, all accesses are full-word.
wb_stb  in  1  strobe.
wb_ack  out  1  acknowledge.
uart_rx  in  1  serial input; asynchronous.
uart_tx  out  1  serial output; idles high.
irq  out  1  level interrupt; registered.

Behaviour:
Registers:
- 0x00 DATA.
  - Write: pushes wb_dat_i[7:0] into the TX FIFO.
  - Read: pops the RX FIFO and returns {24'd0, byte}.
  - Read while RX is empty: returns 0 and the pointers do not move.
- 0x04 STATUS. Bits:
  - [0] RX_NOT_EMPTY.
  - [1] TX_IDLE: TX FIFO empty and the shifter is idle.
  - [2] RX_OVERRUN.
  - [3] FRAME_ERR.
  - [4] PARITY_ERR.
  - [5] TX_FULL.
  - [6] RX_FULL.
  - [7] TX_OVERFLOW.
  - Bits [4:2] and [7] are sticky and are cleared by writing 1 (W1C).
- 0x08 CTRL. Bits:
  - [0] RX_EN.
  - [1] TX_EN.
  - [2] RX_INT_EN.
  - [3] TX_INT_EN.
  - [4] PARITY_EN.
  - [5] PARITY_ODD.
  - [6] STOP2.
  - [7] TX_CLR.
  - [8] RX_CLR.
  - Reset value is 0x003. TX_CLR and RX_CLR are self-clearing and always read 0.
- 0x0C BAUD_DIV [15:0].
  - One oversample tick every BAUD_DIV clocks; baud = CLK_FREQ/(16*BAUD_DIV).
  - Reset value is CLK_FREQ/(16*DEFAULT_BAUD), which is 27 at the default parameters.
  - A value of 0 behaves as 1.
- 0x10 LEVEL.
  - [7:0] holds the TX count and [15:8] holds the RX count. Each count is 0..FIFO_DEPTH.
- Unmapped addresses read 0 and ignore writes.

Wishbone:
- wb_ack <= wb_stb && !wb_ack, so each access takes 1 wait cycle.
- Side effects occur only in the cycle where wb_stb is high and wb_ack is low.
- Reset values: wb_ack=0, wb_dat_o=0, uart_tx=1, irq=0, both FIFOs empty, all sticky flags 0.

FIFOs:
- Circular buffers with wrap-around pointers and a count register.
- Push to a full TX FIFO: the data is dropped and TX_OVERFLOW is set.
- Push and pop in the same cycle: both take effect and the count is unchanged.
- CLR empties the FIFO. A frame already in flight on TX completes.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- Leaves IDLE when TX_EN=1 and the FIFO is non-empty. It pops the FIFO into the shifter and enters START on the next clock.
- Each bit lasts 16 ticks.
- PARITY state is entered only if PARITY_EN=1. Its bit is the XOR of the data, inverted if PARITY_ODD=1.
- STOP lasts 16 ticks, or 32 ticks if STOP2=1.
- Back-to-back frames: no idle gap when the FIFO is non-empty at the end of STOP.
- Clearing TX_EN finishes the current frame and then holds the FSM in IDLE.

RX FSM (IDLE, START, DATA, PARITY, STOP):
- uart_rx passes through a 2-flop synchroniser.
- A falling edge in IDLE with RX_EN=1 enters START, and the tick counter is zeroed.
- Each bit value is the majority of the samples at ticks 7, 8 and 9 of that bit.
- START sampling high means a false start; the FSM returns to IDLE.
- Parity mismatch sets PARITY_ERR.
- A stop bit sampled low sets FRAME_ERR and discards the byte.
- The stop bit is checked once, even if STOP2=1.
- A good byte is pushed at the stop sample. If the RX FIFO is full, the byte is discarded and RX_OVERRUN is set. A byte with a parity error is still pushed.
- Clearing RX_EN aborts the frame and returns to IDLE immediately.

Other rules:
- Baud counter: it is reset on a BAUD_DIV write. A frame in flight continues at the new rate.
- irq <= (RX_INT_EN & RX_NOT_EMPTY) | (TX_INT_EN & TX_IDLE), with one cycle of latency.

Test Plan:
- After reset: a STATUS read returns 0x002 and a CTRL read returns 0x003, with uart_tx high and irq low.
- BAUD_DIV=1: write DATA 0xA5 → uart_tx goes low for 16 clocks, then sends bits 1,0,1,0,0,1,0,1 at 16 clocks each, then high for 16 clocks. TX_IDLE=1 afterwards.
- Write 17 bytes with FIFO_DEPTH=16: 16 frames are sent back-to-back, TX_OVERFLOW is set, and writing 0x80 to STATUS clears it.
- Loop uart_tx to uart_rx with PARITY_EN=1, PARITY_ODD=1, STOP2=1, and send 0x3C → DATA reads 0x3C with no errors and LEVEL shows 0.
- Drive a frame with the stop bit low → FRAME_ERR=1 and RX_NOT_EMPTY=0. Send 17 frames with no reads → RX_OVERRUN=1 and the RX count is 16.
- RX_INT_EN=1, then receive 0x55 → irq rises within 2 clocks of the stop sample and falls one cycle after the DATA read ack. A 1-clock low glitch on uart_rx is rejected as a false start.
